// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle adder summing CHUNK bits per clock, LSB chunk first.
// Optional subtract port enabled by defining CHUNK_SERIAL_ADDER_SUB_EN.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic [WIDTH-1:0] acc_next, b_eff;
    logic [CHUNK:0]   chunk_sum;
    logic [CW-1:0]    cnt;
    logic             c_reg, a_msb, b_msb, cin_eff, last;

    // Subtraction folds into the captured operand: A + ~B + 1.
    always_comb begin
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
    end

    // Operands shift right each cycle; finished chunks enter acc from the top.
    always_comb begin
        chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + (CHUNK+1)'(c_reg);
        acc_next  = (acc >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last      = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            c_reg    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= a;
            op_b  <= b_eff;
            c_reg <= cin_eff;
            cnt   <= '0;
            acc   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
        end else if (state == RUN) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            c_reg <= chunk_sum[CHUNK];
            acc   <= acc_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum      <= acc_next;
                carry    <= chunk_sum[CHUNK];
                overflow <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
            end
        end
    end
endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - directed checks of chunk_serial_adder with WIDTH=16, CHUNK=4.
module tb_chunk_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        busy, done, carry, overflow;
    logic [15:0] sum;
    int          total = 0;
    int          bad = 0;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec, input logic eo);
        int nbusy = 0;
        int lat = -1;
        launch(av, bv, cv);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i - 1;
                break;
            end
            if (busy) nbusy++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " busy_cycles"}, nbusy, 4);
        check({tag, " sum"}, sum, es);
        check({tag, " carry"}, carry, ec);
        check({tag, " overflow"}, overflow, eo);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset carry", carry, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin", 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0);
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start re-asserted with new operands during RUN and DONE.
        launch(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        check("ignore run busy", busy, 1);
        check("ignore run sum_held", sum, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("ignore run sum_held2", sum, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("ignore done", done, 1);
        check("ignore sum", sum, 16'h2345);
        check("ignore carry", carry, 0);
        @(negedge clk);
        check("ignore done_to_idle", busy, 0);
        check("ignore no_second_done", done, 0);
        start = 1'b0;
        @(negedge clk);
        check("ignore stays_idle", busy, 0);
        check("ignore sum_kept", sum, 16'h2345);

        // Reset two cycles into RUN.
        launch(16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("abort no_done", seen, 0);
        end
        run_op("after_abort", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
        sub = 1'b0;
        run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chunk_serial_adder.md
CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle. WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured when start is accepted.
REQ-007 b  input  WIDTH  operand B; captured when start is accepted.
REQ-008 cin  input  1  carry-in; captured when start is accepted.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  WIDTH  result; held stable between completions.
REQ-012 carry  output  1  carry-out of the MSB.
REQ-013 overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at edge T: SHALL capture a, b and cin (and sub, see REQ-027), clear the chunk counter, and enter RUN.
REQ-016 RUN, edges T+1..T+N: SHALL add one chunk per edge, chunk k being bits [k*CHUNK +: CHUNK], LSB chunk first, with the carry held in a register between chunks.
REQ-017 At edge T+N the FSM SHALL enter DONE and load sum, carry and overflow from the completed result in that same edge; done SHALL be high for exactly that one cycle.
REQ-018 DONE SHALL return to IDLE at the next edge unconditionally; start high in DONE SHALL be ignored.
REQ-019 Latency SHALL be N cycles from the edge that accepts start to done high; throughput SHALL be one operation per N+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change during an operation.
REQ-021 sum, carry and overflow SHALL change only on completion (or on reset) and SHALL NOT expose partial results during RUN.
REQ-022 Overflow SHALL equal (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is the effective second operand.
REQ-023 When CHUNK==WIDTH (N=1), the operation SHALL complete in a single RUN cycle with the same protocol.

Reset
REQ-024 rst high SHALL force IDLE immediately, independent of clk.
REQ-025 On reset: busy=0, done=0, sum=0, carry=0, overflow=0, and the internal counter and operand registers SHALL be cleared.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the first start after rst falls SHALL be accepted normally.

Configuration
REQ-027 Macro CHUNK_SERIAL_ADDER_SUB_EN defined: SHALL add port "sub  input  1", captured with start.
  - sub=1: compute A + ~B + 1, with cin ignored; carry=1 means no borrow.
  - sub=0: plain addition.
REQ-028 Macro undefined: the sub port SHALL NOT exist and the block SHALL perform addition only, with behaviour identical to sub=0.

Verification (WIDTH=16, CHUNK=4)
REQ-029 a=0x0000, b=0x0000, cin=0, start -> done exactly 4 cycles later; sum=0x0000, carry=0, overflow=0; busy high for 4 cycles.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1, overflow=0. Also a=0x1234, b=0x0000, cin=1 -> sum=0x1235.
REQ-031 a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, carry=1, overflow=1.
REQ-032 Second start with new operands asserted during RUN and during DONE -> ignored; the first result is delivered, and sum stays at the previous value until done.
REQ-033 rst asserted 2 cycles into RUN -> outputs 0 and busy 0 immediately; no done pulse; a subsequent start completes correctly.
REQ-034 With CHUNK_SERIAL_ADDER_SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, carry=0. Also a=0x0007, b=0x0005 -> sum=0x0002, carry=1.
